// File: rtl/seg_scan_arbiter.sv
// Four-digit seven-segment scan controller shared by two sources, with
// frame-aligned exclusive-display arbitration and anti-ghosting blanking.
module seg_scan_arbiter #(
  parameter int DIV            = 1024,
  parameter int BLANK          = 16,
  parameter int MAX_FRAMES     = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        clk_raw,
  input  logic        reset,
  input  logic [15:0] a_val,
  input  logic [3:0]  a_en,
  input  logic        a_req,
  output logic        a_gnt,
  input  logic [15:0] b_val,
  input  logic [3:0]  b_en,
  input  logic        b_req,
  output logic        b_gnt,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        f,
  output logic        g,
  output logic        numsl0,
  output logic        numsl1,
  output logic        numsl2,
  output logic        numsl3,
  output logic        frame_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW = $clog2(MAX_FRAMES + 1);
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};

  typedef enum logic [1:0] {SPLIT, OWN_A, OWN_B} state_t;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  state_t        r_state;
  logic          r_last_b;
  logic [HW-1:0] r_hold;
  logic          r_a_gnt;
  logic          r_b_gnt;
  logic          r_tick;
  logic [3:0]    r_numsl;
  logic [6:0]    r_seg;

  logic          w_wrap;
  logic          w_boundary;
  logic          w_blank;
  logic          w_own_a;
  logic [15:0]   w_val;
  logic [3:0]    w_en;
  logic [3:0]    w_nib;
  logic [6:0]    w_hex;

  assign w_wrap     = (r_cnt == CW'(DIV - 1));
  assign w_boundary = w_wrap && (r_idx == 2'd3);
  assign w_blank    = (r_cnt < CW'(BLANK));
  // In SPLIT mode A owns digits 0-1, B owns digits 2-3.
  assign w_own_a    = (r_state == OWN_A) || ((r_state == SPLIT) && !r_idx[1]);
  assign w_val      = w_own_a ? a_val : b_val;
  assign w_en       = w_own_a ? a_en : b_en;
  assign w_nib      = w_val[{r_idx, 2'b00} +: 4];

  always_comb begin
    w_hex = 7'h00;
    case (w_nib)
      4'h0: w_hex = 7'h3F;
      4'h1: w_hex = 7'h06;
      4'h2: w_hex = 7'h5B;
      4'h3: w_hex = 7'h4F;
      4'h4: w_hex = 7'h66;
      4'h5: w_hex = 7'h6D;
      4'h6: w_hex = 7'h7D;
      4'h7: w_hex = 7'h07;
      4'h8: w_hex = 7'h7F;
      4'h9: w_hex = 7'h6F;
      4'hA: w_hex = 7'h77;
      4'hB: w_hex = 7'h7C;
      4'hC: w_hex = 7'h39;
      4'hD: w_hex = 7'h5E;
      4'hE: w_hex = 7'h79;
      4'hF: w_hex = 7'h71;
      default: w_hex = 7'h00;
    endcase
  end

  always_ff @(posedge clk_raw) begin
    if (reset) begin
      r_cnt    <= '0;
      r_idx    <= 2'd0;
      r_state  <= SPLIT;
      r_last_b <= 1'b1;
      r_hold   <= '0;
      r_a_gnt  <= 1'b0;
      r_b_gnt  <= 1'b0;
      r_tick   <= 1'b0;
      r_numsl  <= 4'hF;
      r_seg    <= SEG_OFF;
    end else begin
      r_cnt   <= w_wrap ? '0 : r_cnt + 1'b1;
      r_idx   <= w_wrap ? r_idx + 2'd1 : r_idx;
      r_tick  <= w_boundary;
      r_numsl <= w_blank ? 4'hF : ~(4'b0001 << r_idx);
      r_seg   <= ((w_blank || !w_en[r_idx]) ? 7'h00 : w_hex) ^ SEG_OFF;

      if (w_boundary) begin
        case (r_state)
          SPLIT: begin
            if (a_req && (!b_req || r_last_b)) begin
              r_state <= OWN_A; r_a_gnt <= 1'b1; r_b_gnt <= 1'b0;
              r_hold  <= HW'(1); r_last_b <= 1'b0;
            end else if (b_req) begin
              r_state <= OWN_B; r_a_gnt <= 1'b0; r_b_gnt <= 1'b1;
              r_hold  <= HW'(1); r_last_b <= 1'b1;
            end
          end
          OWN_A: begin
            if (b_req && (!a_req || r_hold == HW'(MAX_FRAMES))) begin
              r_state <= OWN_B; r_a_gnt <= 1'b0; r_b_gnt <= 1'b1;
              r_hold  <= HW'(1); r_last_b <= 1'b1;
            end else if (!a_req) begin
              r_state <= SPLIT; r_a_gnt <= 1'b0; r_b_gnt <= 1'b0;
              r_hold  <= '0;
            end else if (r_hold != HW'(MAX_FRAMES)) begin
              // Saturate so a long uncontested hold still yields promptly.
              r_hold <= r_hold + 1'b1;
            end
          end
          OWN_B: begin
            if (a_req && (!b_req || r_hold == HW'(MAX_FRAMES))) begin
              r_state <= OWN_A; r_a_gnt <= 1'b1; r_b_gnt <= 1'b0;
              r_hold  <= HW'(1); r_last_b <= 1'b0;
            end else if (!b_req) begin
              r_state <= SPLIT; r_a_gnt <= 1'b0; r_b_gnt <= 1'b0;
              r_hold  <= '0;
            end else if (r_hold != HW'(MAX_FRAMES)) begin
              r_hold <= r_hold + 1'b1;
            end
          end
          default: begin
            r_state <= SPLIT; r_a_gnt <= 1'b0; r_b_gnt <= 1'b0;
            r_hold  <= '0;
          end
        endcase
      end
    end
  end

  assign a_gnt      = r_a_gnt;
  assign b_gnt      = r_b_gnt;
  assign frame_tick = r_tick;
  assign {g, f, e, d, c, b, a} = r_seg;
  assign {numsl3, numsl2, numsl1, numsl0} = r_numsl;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Bench for seg_scan_arbiter: directed phases followed by random traffic,
// all compared each cycle against a cycle-count based reference model.
module tb_seg_scan_arbiter;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int MAXF  = 2;

  logic        clk_raw = 1'b0;
  logic        reset;
  logic [15:0] a_val, b_val;
  logic [3:0]  a_en, b_en;
  logic        a_req, b_req;
  logic        a_gnt, b_gnt;
  logic        a, b, c, d, e, f, g;
  logic        numsl0, numsl1, numsl2, numsl3;
  logic        frame_tick;

  seg_scan_arbiter #(
    .DIV(DIV), .BLANK(BLANK), .MAX_FRAMES(MAXF), .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk_raw(clk_raw), .reset(reset),
    .a_val(a_val), .a_en(a_en), .a_req(a_req), .a_gnt(a_gnt),
    .b_val(b_val), .b_en(b_en), .b_req(b_req), .b_gnt(b_gnt),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .numsl0(numsl0), .numsl1(numsl1), .numsl2(numsl2), .numsl3(numsl3),
    .frame_tick(frame_tick)
  );

  always #5 clk_raw = ~clk_raw;

  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_checks = 0;
  int n_fail   = 0;

  // Model: n = cycles since reset release; owner 0 = split, 1 = A, 2 = B.
  int  n;
  int  m_owner;
  int  m_last;
  int  m_hold;
  int  frame_no;
  logic [3:0] e_numsl;
  logic [6:0] e_seg;
  logic       e_tick, e_ag, e_bg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at n=%0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  task automatic take(input int who);
    m_owner = who;
    m_last  = who;
    m_hold  = 1;
  endtask

  task automatic arbitrate();
    bit req [3];
    int x, y;
    req[1] = a_req;
    req[2] = b_req;
    if (m_owner == 0) begin
      if (req[1] && req[2]) take(3 - m_last);
      else if (req[1]) take(1);
      else if (req[2]) take(2);
    end else begin
      x = m_owner;
      y = 3 - x;
      if (!req[x]) begin
        if (req[y]) take(y);
        else m_owner = 0;
      end else if (req[y] && m_hold >= MAXF) take(y);
      else m_hold++;
    end
  endtask

  task automatic step();
    int cnt, idx, owner;
    logic [15:0] v;
    logic [3:0]  en;
    if (reset) begin
      n = 0; m_owner = 0; m_last = 2; m_hold = 0;
      e_numsl = 4'hF; e_seg = 7'h00; e_tick = 1'b0; e_ag = 1'b0; e_bg = 1'b0;
    end else begin
      cnt   = n % DIV;
      idx   = (n / DIV) % 4;
      owner = (m_owner != 0) ? m_owner : ((idx < 2) ? 1 : 2);
      v     = (owner == 1) ? a_val : b_val;
      en    = (owner == 1) ? a_en : b_en;
      e_numsl = (cnt < BLANK) ? 4'hF : 4'(~(4'b0001 << idx));
      e_seg   = (cnt < BLANK || !en[idx]) ? 7'h00 : hex_tbl[v[idx*4 +: 4]];
      e_tick  = (cnt == DIV - 1) && (idx == 3);
      if (e_tick) arbitrate();
      e_ag = (m_owner == 1);
      e_bg = (m_owner == 2);
      n++;
    end
    @(posedge clk_raw);
    #1;
    check("numsl", 32'({numsl3, numsl2, numsl1, numsl0}), 32'(e_numsl));
    check("seg", 32'({g, f, e, d, c, b, a}), 32'(e_seg));
    check("frame_tick", 32'(frame_tick), 32'(e_tick));
    check("a_gnt", 32'(a_gnt), 32'(e_ag));
    check("b_gnt", 32'(b_gnt), 32'(e_bg));
    check("gnt_excl", 32'(a_gnt & b_gnt), 32'd0);
    if (frame_tick) begin
      frame_no++;
      $display("frame %0d: a_gnt=%0b b_gnt=%0b a_req=%0b b_req=%0b", frame_no, a_gnt, b_gnt, a_req, b_req);
    end
    @(negedge clk_raw);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic wait_owner(input int who, input string tag);
    for (int i = 0; i < 400 && m_owner != who; i++) step();
    check(tag, 32'(who == 1 ? a_gnt : b_gnt), 32'd1);
  endtask

  initial begin
    frame_no = 0;
    reset = 1'b1;
    a_val = '0; b_val = '0; a_en = '0; b_en = '0; a_req = 1'b0; b_req = 1'b0;
    @(negedge clk_raw);
    run(3);

    reset = 1'b0;
    a_val = 16'h0021; b_val = 16'hF800; a_en = 4'hF; b_en = 4'hF;
    run(8 * DIV);

    a_en = 4'b1110;
    run(4 * DIV);
    a_en = 4'hF;

    for (int i = 0; i < 4 * DIV && !((n % DIV) == 3 && ((n / DIV) % 4) == 1); i++) step();
    a_req = 1'b1;
    run(8 * DIV);
    a_req = 1'b0;
    run(8 * DIV);

    reset = 1'b1;
    run(1);
    reset = 1'b0;
    a_req = 1'b1; b_req = 1'b1;
    run(28 * DIV);

    wait_owner(2, "reach_own_b");
    a_req = 1'b0;
    run(4 * DIV);
    b_req = 1'b0;
    run(8 * DIV);

    b_req = 1'b1;
    wait_owner(2, "regrant_b");
    run(DIV + 3);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    b_req = 1'b0;
    run(2 * DIV);

    for (int i = 0; i < 3000; i++) begin
      a_val = 16'($urandom);
      b_val = 16'($urandom);
      if ($urandom_range(0, 7) == 0) a_en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) b_en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) a_req = ~a_req;
      if ($urandom_range(0, 39) == 0) b_req = ~b_req;
      reset = ($urandom_range(0, 599) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_arbiter.md
# seg_scan_arbiter

Time-multiplexed 4-digit seven-segment scan controller that shares the display between two requesters: source A (UART receive side) and source B (UART transmit side). It generates the digit-select scan with anti-ghosting blanking and hex-decodes each source's nibbles. It arbitrates exclusive full-display requests, switching ownership only at frame boundaries so a frame never shows mixed content. It sits between the two task blocks and the board's a..g / numsl0..3 pins, replacing ad-hoc output muxing.

## Interface
- DIV, 1024: clock cycles per digit slot; requires DIV >= BLANK+2.
- BLANK, 16: cycles at the start of each slot with all digits deselected.
- MAX_FRAMES, 8: frames an owner may hold the display while the other source is requesting.
- SEG_ACTIVE_LOW, 0: 1 inverts all seven segment outputs.

- clk_raw  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- a_val  in  16  source A nibbles; [3:0] = digit 0 … [15:12] = digit 3.
- a_en  in  4  per-digit enable for A; 0 blanks that digit.
- a_req  in  1  A requests the whole display (level).
- a_gnt  out  1  A owns the whole display.
- b_val, b_en, b_req, b_gnt: same as the A ports, for source B.
- a, b, c, d, e, f, g  out  1 each  segment drives (active-high unless SEG_ACTIVE_LOW).
- numsl0..numsl3  out  1 each  digit selects, active-low, at most one low.
- frame_tick  out  1  one-cycle pulse in the first cycle of each frame.

## Operation
- Counters: slot counter cnt runs 0..DIV-1. When it wraps, digit index idx increments mod 4. A frame is idx 0..3, i.e. 4·DIV cycles.
- Frame boundary: the edge where cnt==DIV-1 and idx==3. Arbitration updates only on this edge.
- Arbiter states:
  - SPLIT: digits 0–1 owned by A, digits 2–3 owned by B.
  - OWN_A / OWN_B: all four digits owned by that source.
- Boundary transitions:
  - From SPLIT: only a_req → OWN_A. Only b_req → OWN_B. Both → the source that is not last_winner. Neither → stay in SPLIT.
  - From OWN_X: X's request dropped → OWN_Y if Y requests, else SPLIT. Y requests and hold==MAX_FRAMES → OWN_Y. Otherwise stay in OWN_X and increment hold.
- Entering any OWN state sets hold=1 and last_winner to the new owner.
- a_gnt = (state==OWN_A), b_gnt = (state==OWN_B), both registered with the state.
- Digit content: take the owner's en[idx] and val nibble. en=0 → all segments off. Otherwise hex-decode, bus {g,f,e,d,c,b,a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- During blanking (cnt < BLANK): all numsl high and segments off.
- Inputs are sampled live every cycle. Value changes mid-slot are shown from the next cycle.

## Timing
- Reset values:
  - cnt=0, idx=0, state=SPLIT, last_winner=B (so A wins the first tie), hold=0.
  - numsl0..3=1, segments off, a_gnt=b_gnt=0, frame_tick=0.
- Segment and digit-select outputs are registered from the current (cnt, idx, state). Visible latency is 1 cycle.
- numsl[idx] is low for DIV-BLANK cycles per slot.
- frame_tick is set on the boundary edge. It is high during the first cycle of the new frame, coincident with the updated gnt values.
- A request raised mid-frame is granted at the next boundary: latency ≤ 4·DIV cycles.
- Reset asserted in any cycle returns every register to its reset value on that edge, including a grant held mid-frame.
- Simultaneous request and release at a boundary: use the request levels sampled on the boundary edge only.

## Test plan
- Reset, DIV=8, BLANK=2: outputs at reset values during reset. First numsl0 low 3 cycles after reset release, lasting 6 cycles. numsl1 low follows 2 blank cycles later.
- Split decode: a_val=16'h0021, b_val=16'hF800, all en=4'hF, no reqs → slots 0..3 show 06, 5B, 7F, 71.
- Enable blank: a_en=4'b1110 → digit 0 slot shows numsl0 low with segments 00. Other digits unchanged.
- Grant at boundary: a_req rises at cnt=3, idx=1 → a_gnt rises with the next frame_tick. All 4 digits then show a_val nibbles. b_gnt stays 0.
- Fairness, MAX_FRAMES=2: both requests held from reset → A for 2 frames, B for 2, A for 2. Exactly one gnt high at a time.
- Release and reset: drop b_req while OWN_B → SPLIT at the next boundary. Reset asserted mid-frame with b_gnt=1 → next cycle b_gnt=0, all numsl=1, segments off.
